// File: rtl/lab3_dec_pkg.sv
// rtl/lab3_dec_pkg.sv - shared types and widths for the sequenced 2-to-4 decoder
package lab3_dec_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic [1:0] a;
        logic       v;
    } code_word_t;

endpackage

// File: rtl/lab3_decoder_4bit_seq_if.sv
// rtl/lab3_decoder_4bit_seq_if.sv - encoded-word handshake between encoder side and decoder
interface lab3_decoder_4bit_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] Ain;
    logic       Vin;

    modport master (
        output in_valid,
        output Ain,
        output Vin,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  Ain,
        input  Vin,
        output in_ready
    );
endinterface

// File: rtl/lab3_dec_onehot.sv
// rtl/lab3_dec_onehot.sv - combinational 2-to-4 one-hot decoder with enable
module lab3_dec_onehot (
    input  logic [1:0] a,
    input  logic       en,
    output logic [3:0] d
);
    always_comb begin
        d = 4'b0000;
        if (en) begin
            d[a] = 1'b1;
        end
    end
endmodule

// File: rtl/lab3_decoder_4bit_seq.sv
// rtl/lab3_decoder_4bit_seq.sv - sequenced decoder: hold one-hot word, then gap; one pending slot
// Optional LAB3_DEC_CNT_EN adds the word_cnt output counting displayed words.
module lab3_decoder_4bit_seq
    import lab3_dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lab3_decoder_4bit_seq_if.slave   up,
    output logic [3:0]               D,
    output logic                     D_valid,
    output logic                     busy
`ifdef LAB3_DEC_CNT_EN
    ,
    output logic [CNT_W-1:0]         word_cnt
`endif
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    code_word_t       pend_q;
    logic             pend_full_q, pend_full_d;
    logic [3:0]       dec_d, d_d;
    logic             d_valid_d, busy_d;
    logic             phase_end, hold_last, gap_last, load_now, xfer;

    assign phase_end = (cnt_q == '0);
    assign hold_last = (state_q == HOLD) && phase_end;
    assign gap_last  = (state_q == GAP)  && phase_end;

    // A pending word moves to the display exactly when the current phase sequence ends.
    assign load_now  = pend_full_q &&
                       ((state_q == IDLE) || (hold_last && (GAP_CYCLES == 0)) || gap_last);
    assign up.in_ready = !pend_full_q || load_now;
    assign xfer        = up.in_valid && up.in_ready;

    lab3_dec_onehot u_onehot (
        .a  (pend_q.a),
        .en (pend_q.v),
        .d  (dec_d)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_now) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            HOLD: begin
                if (!phase_end) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (GAP_CYCLES != 0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end else if (load_now) begin
                    cnt_d = HOLD_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (!phase_end) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (load_now) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pend_full_d = pend_full_q;
        if (xfer) begin
            pend_full_d = 1'b1;
        end else if (load_now) begin
            pend_full_d = 1'b0;
        end
        d_valid_d = (state_d == HOLD);
        d_d       = 4'b0000;
        if (load_now) begin
            d_d = dec_d;
        end else if (d_valid_d) begin
            d_d = D;
        end
        busy_d = (state_d != IDLE) || pend_full_d;
    end

    // Outputs are registered so D, D_valid and busy come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            D           <= 4'b0000;
            D_valid     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            if (xfer) begin
                pend_q <= '{a: up.Ain, v: up.Vin};
            end
            D           <= d_d;
            D_valid     <= d_valid_d;
            busy        <= busy_d;
        end
    end

`ifdef LAB3_DEC_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (hold_last) begin
            word_cnt <= word_cnt + CNT_ONE;
        end
    end
`endif

endmodule
